stopwatch_scan_display: RTL
===========================

// Module: stopwatch_scan_display
// PURPOSE
//  Parametrised stopwatch plus multiplexed 7-segment driver.
//  Keeps an N_DIGITS BCD time value (cc, SS, MM, ...), counting up or down from a preload.
//  Supports a lap-freeze display and scans the digits onto a shared segment bus.
//  Sits directly under the board top level, between the push-button inputs and the LED pins.
// PARAMETERS
//  CLK_HZ          50_000_000  system clock frequency
//  TICK_HZ         100         count rate (100 = hundredths of a second)
//  SCAN_HZ         1000        full-frame refresh rate of the display
//  N_DIGITS        6           digits, 2..8; radix per digit (LSD first): 10,10,10,6,10,6,10,10
//  SEG_ACTIVE_LOW  1           1: seg bit low = segment lit
//  DIG_ACTIVE_LOW  1           1: dig bit low = digit enabled
// PORTS
//  clk       in   1            system clock
//  rst       in   1            asynchronous reset, active-low
//  start     in   1            single-cycle pulse: toggle run/stop
//  lap       in   1            single-cycle pulse: toggle display freeze
//  mode      in   1            0 = count up, 1 = count down; sampled only while stopped
//  load      in   1            single-cycle pulse: load load_val into the counter
//  load_val  in   4*N_DIGITS   BCD preload, LSD in [3:0]
//  count     out  4*N_DIGITS   live BCD count, registered
//  running   out  1            1 while counting
//  done      out  1            down-count reached zero; sticky
//  out       out  7            segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//  dig       out  N_DIGITS     one-hot digit enable, polarity per DIG_ACTIVE_LOW
// BEHAVIOUR
//  Reset values (rst low)
//   - count=0, running=0, done=0, frozen=0, scan index=0.
//   - out and dig driven to all-off.
//  Prescaler
//   - tick is a 1-cycle pulse every CLK_HZ/TICK_HZ clocks while running.
//   - Prescaler clears whenever running is 0, so the first tick lands exactly CLK_HZ/TICK_HZ clocks after start.
//  Run states: STOP, RUN, DONE
//   - STOP -> RUN: on start, unless mode=1 and count=0.
//   - RUN -> STOP: on start.
//   - RUN -> DONE: on a down tick that makes count 0; running=0, done=1 in the same cycle count shows 0.
//   - DONE -> STOP: on load; done clears.
//   - start is ignored in DONE.
//  Arithmetic
//   - Ripple BCD carry/borrow per digit radix.
//   - Up-count at all-max (e.g. 59:59:99) wraps to 0 and keeps running.
//   - Down-count borrows each digit back to radix-1.
//   - Each digit in the mode latch is frozen while running; mode changes during RUN have no effect until the next STOP.
//  Load
//   - In any state: count <= load_val, next state is STOP, done=0.
//   - Any load_val digit >= its radix is clamped to radix-1.
//  Simultaneous events
//   - load has priority over start and tick in the same cycle.
//   - start + tick in the same cycle: the tick is applied, then the state toggles.
//   - lap acts independently of the others.
//  Lap freeze
//   - lap with frozen=0 captures count into the display register and sets frozen=1.
//   - The next lap releases it; counting continues underneath.
//   - load or reset forces frozen=0.
//  Scan
//   - Each digit is displayed for CLK_HZ/(SCAN_HZ*N_DIGITS) clocks; index runs 0..N_DIGITS-1 then wraps to 0.
//   - out/dig are registered, 1-cycle latency from the index change; never two digits enabled at once.
//   - After reset, digit 0 is enabled from the first clock edge after rst deasserts.
//  Reset mid-count: asynchronous clear of all state; no partial tick is retained.
// STRUCTURE
//  Shared package stopwatch_pkg:
//   - 7-segment patterns for 0-9 (active-high) and the digit radix table function.
//   - Constants for the run-state encoding.
//  One sub-module seg7_decode: combinational BCD -> segments, blank for codes 10-15.
//  Counter, prescaler, lap register and scan logic stay in this module.
// TESTING (bench uses CLK_HZ=1000, TICK_HZ=100, SCAN_HZ=50, N_DIGITS=6; tick every 10 clocks)
//  1. Release rst, start pulse:
//     - count=000001 exactly 10 clocks later;
//     - after 100 ticks count=000100.
//  2. load 595999, mode=0, start:
//     - next tick gives 000000 with running still 1 (wrap).
//  3. load 000002, mode=1, start:
//     - 2 ticks later count=0, done=1, running=0;
//     - further start pulses are ignored until load.
//  4. lap at count=000050:
//     - scanned digits keep showing 50 while count advances;
//     - second lap resumes live display.
//  5. load 00009F (invalid LSD): count=000099.
//     - load+start in the same cycle: state STOP, count=load_val.
//  6. Scan check:
//     - dig one-hot, step every 3 clocks, index 5 wraps to 0;
//     - out matches seg7_decode of the displayed digit;
//     - rst mid-run: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: run-state encoding, per-digit radix table and 7-segment patterns
package stopwatch_pkg;
  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DONE} run_state_t;

  // Digit radix LSD first: cc (10,10), SS (10,6), MM (10,6), HH (10,10)
  function automatic logic [3:0] radix(input int i);
    return (i == 3 || i == 5) ? 4'd6 : 4'd10;
  endfunction

  // Active-high {g,f,e,d,c,b,a}; codes 10-15 blank
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3f;
      4'd1: return 7'h06;
      4'd2: return 7'h5b;
      4'd3: return 7'h4f;
      4'd4: return 7'h66;
      4'd5: return 7'h6d;
      4'd6: return 7'h7d;
      4'd7: return 7'h07;
      4'd8: return 7'h7f;
      4'd9: return 7'h6f;
      default: return 7'h00;
    endcase
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to active-high segments, blank above 9
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = seg7(bcd);
endmodule

// File: rtl/stopwatch_scan_display.sv
// stopwatch_scan_display: BCD up/down stopwatch with lap freeze and a
// multiplexed 7-segment scanner driving a shared segment bus.
module stopwatch_scan_display
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICK_HZ        = 100,
  parameter int SCAN_HZ        = 1000,
  parameter int N_DIGITS       = 6,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  lap,
  input  logic                  mode,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  running,
  output logic                  done,
  output logic [6:0]            out,
  output logic [N_DIGITS-1:0]   dig
);
  localparam int W        = 4 * N_DIGITS;
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / (SCAN_HZ * N_DIGITS);
  localparam int PW       = $clog2(TICK_DIV) + 1;
  localparam int SW       = $clog2(SCAN_DIV) + 1;
  localparam int IW       = $clog2(N_DIGITS);
  localparam logic [6:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic [N_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

  run_state_t           state, state_nx;
  logic [W-1:0]         count_nx, clamped, disp, shown;
  logic [PW-1:0]        pre;
  logic [SW-1:0]        sc;
  logic [IW-1:0]        idx;
  logic [3:0]           d, r, ld, cur;
  logic [6:0]           seg;
  logic [N_DIGITS-1:0]  dig_oh;
  logic                 mode_q, frozen, tick, carry;

  assign running = state == ST_RUN;
  assign done    = state == ST_DONE;
  assign tick    = running && pre == PW'(TICK_DIV - 1);
  assign shown   = frozen ? disp : count;
  assign dig_oh  = N_DIGITS'(1) << idx;

  // Ripple carry/borrow through the digits; also clamps the preload per radix
  always_comb begin
    count_nx = count;
    clamped  = load_val;
    carry    = 1'b1;
    d        = '0;
    r        = '0;
    ld       = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      d  = count[4*i +: 4];
      r  = radix(i);
      ld = load_val[4*i +: 4];
      count_nx[4*i +: 4] = !carry ? d
                         : mode_q ? (d == 4'd0 ? r - 4'd1 : d - 4'd1)
                         : (d == r - 4'd1 ? 4'd0 : d + 4'd1);
      carry = carry && (mode_q ? d == 4'd0 : d == r - 4'd1);
      clamped[4*i +: 4] = ld >= r ? r - 4'd1 : ld;
    end
  end

  // A tick coinciding with start is applied first; reaching zero wins over the toggle
  always_comb begin
    state_nx = load ? ST_STOP
             : (state == ST_STOP && start && !(mode && count == '0)) ? ST_RUN
             : (state == ST_RUN && tick && mode_q && count_nx == '0) ? ST_DONE
             : (state == ST_RUN && start) ? ST_STOP
             : state;
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (idx == IW'(i)) cur = shown[4*i +: 4];
  end

  seg7_decode u_dec (.bcd(cur), .seg(seg));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_STOP;
      count  <= '0;
      pre    <= '0;
      mode_q <= 1'b0;
      frozen <= 1'b0;
      disp   <= '0;
      sc     <= '0;
      idx    <= '0;
      out    <= SEG_OFF;
      dig    <= DIG_OFF;
    end else begin
      state  <= state_nx;
      count  <= load ? clamped : tick ? count_nx : count;
      pre    <= (tick || !running) ? '0 : pre + PW'(1);
      mode_q <= running ? mode_q : mode;
      frozen <= load ? 1'b0 : lap ? !frozen : frozen;
      disp   <= (lap && !frozen) ? count : disp;
      sc     <= sc == SW'(SCAN_DIV - 1) ? '0 : sc + SW'(1);
      idx    <= sc != SW'(SCAN_DIV - 1) ? idx : idx == IW'(N_DIGITS - 1) ? '0 : idx + IW'(1);
      out    <= seg ^ SEG_OFF;
      dig    <= dig_oh ^ DIG_OFF;
    end
  end
endmodule
